// File: rtl/bcd_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter_pkg
// Brief    : Shared constants and helpers for the BCD modulo-N counters
//            used in the time-of-day clock datapath.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_mod_counter_pkg;

  // Width and largest legal value of one BCD digit
  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Standard moduli for the time-of-day chain
  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;

  // Widest counter the constant generator below can describe
  localparam int MAX_DIGITS = 8;

  // Convert a binary integer to packed BCD, digit 0 in the low nibble.
  // Used at elaboration time to build the terminal-count constant.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    int unsigned                 v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter_digit
// Brief    : One BCD digit of the modulo counter. Increments or decrements
//            when its carry/borrow input is set, or loads a value supplied by
//            the top level (parallel load, illegal-load clear, modulus wrap).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_counter_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic             CP,
  input  logic             nCLR,
  input  logic             i_ci,   // carry-in (up) / borrow-in (down)
  input  logic             i_up,
  input  logic             i_ld,   // load i_d, overrides counting
  input  logic [BCD_W-1:0] i_d,
  output logic [BCD_W-1:0] o_q,
  output logic             o_co    // carry-out (up) / borrow-out (down)
);

  logic [BCD_W-1:0] r_q;
  logic [BCD_W-1:0] w_next;

  // Next digit value when counting: roll 9->0 up, 0->9 down
  always_comb begin
    w_next = r_q;
    if (i_up) begin
      if (r_q >= BCD_MAX) w_next = '0;
      else                w_next = r_q + 4'd1;
    end else begin
      if (r_q == '0)      w_next = BCD_MAX;
      else                w_next = r_q - 4'd1;
    end
  end

  // Digit register: load has priority over counting, otherwise hold
  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR)     r_q <= '0;
    else if (i_ld) r_q <= i_d;
    else if (i_ci) r_q <= w_next;
  end

  // The next digit only moves when this one rolls over in the count direction
  assign o_co = i_ci & (i_up ? (r_q == BCD_MAX) : (r_q == '0));
  assign o_q  = r_q;

endmodule
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter
// Brief    : Parametrised multi-digit BCD modulo-N up/down counter with
//            synchronous range-checked load and cascade terminal-count output.
//            Chain CO -> EN of the next stage to build wider counters.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = MOD_SEC
)(
  input  logic                  CP,
  input  logic                  nCLR,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LD,
  input  logic [BCD_W*DIGITS-1:0] D,
  output logic [BCD_W*DIGITS-1:0] Q,
  output logic                  CO,
  output logic                  ERR
);

  localparam int QW = BCD_W * DIGITS;

  // MODULUS-1 as a BCD constant; wrap target when counting down and the
  // upper bound for the load range check
  localparam logic [BCD_W*MAX_DIGITS-1:0] c_max_all = to_bcd(MODULUS - 1);
  localparam logic [QW-1:0]               c_max     = c_max_all[QW-1:0];

  logic [QW-1:0]     w_q;
  logic [DIGITS-1:0] w_dig_ok;
  logic              w_ld_legal;
  logic              w_term;
  logic              w_wrap;
  logic              w_dig_ld;
  logic [QW-1:0]     w_ld_val;
  logic [DIGITS:0]   w_carry;
  logic              w_unused_carry;
  logic              r_err;

  // Per-digit BCD validity of the load value
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig_chk
      assign w_dig_ok[gi] = (D[BCD_W*gi +: BCD_W] <= BCD_MAX);
    end
  endgenerate

  // With every digit valid, comparing the BCD strings as unsigned numbers
  // orders them the same as their decimal values
  assign w_ld_legal = (&w_dig_ok) & (D <= c_max);

  // Terminal value in the current direction, checked on the whole value
  // rather than per digit (e.g. 19 -> 20 is an ordinary carry for mod 24)
  assign w_term = UP ? (w_q == c_max) : (w_q == '0);
  assign CO     = EN & w_term;

  // A modulus wrap is forced through the digit load path
  assign w_wrap   = ~LD & EN & w_term;
  assign w_dig_ld = LD | w_wrap;

  // Value presented on the digit load path: legal D, zero for an illegal
  // load or an upward wrap, MODULUS-1 for a downward wrap
  always_comb begin
    w_ld_val = '0;
    if (LD) begin
      if (w_ld_legal) w_ld_val = D;
    end else if (!UP) begin
      w_ld_val = c_max;
    end
  end

  // Ripple carry/borrow enable through the digits; load overrides counting
  assign w_carry[0] = EN & ~LD;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_mod_counter_digit u_digit (
        .CP   (CP),
        .nCLR (nCLR),
        .i_ci (w_carry[gi]),
        .i_up (UP),
        .i_ld (w_dig_ld),
        .i_d  (w_ld_val[BCD_W*gi +: BCD_W]),
        .o_q  (w_q[BCD_W*gi +: BCD_W]),
        .o_co (w_carry[gi+1])
      );
    end
  endgenerate

  // Carry out of the top digit is superseded by the whole-value wrap
  assign w_unused_carry = w_carry[DIGITS];

  // Error flag: set for exactly the cycle following an illegal load
  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) r_err <= 1'b0;
    else       r_err <= LD & ~w_ld_legal;
  end

  assign Q   = w_q;
  assign ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_mod_counter
// Brief    : Self-checking bench for bcd_mod_counter. Three instances form a
//            seconds/minutes/hours chain; each can also be driven on its own.
//            An integer reference model tracks every instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_mod_counter;
  import bcd_mod_counter_pkg::*;

  logic       clk = 1'b0;
  logic       nclr;
  logic       casc;
  logic       en [3];
  logic       up [3];
  logic       ld [3];
  logic [7:0] d  [3];
  logic [7:0] q  [3];
  logic       co [3];
  logic       err[3];
  logic       en_min, en_hour;

  int mods[3];
  int mv  [3];
  int merr[3];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign en_min  = casc ? co[0] : en[1];
  assign en_hour = casc ? co[1] : en[2];

  bcd_mod_counter #(.DIGITS(2), .MODULUS(MOD_SEC)) u_sec (
    .CP(clk), .nCLR(nclr), .EN(en[0]), .UP(up[0]), .LD(ld[0]), .D(d[0]),
    .Q(q[0]), .CO(co[0]), .ERR(err[0]));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(MOD_MIN)) u_min (
    .CP(clk), .nCLR(nclr), .EN(en_min), .UP(up[1]), .LD(ld[1]), .D(d[1]),
    .Q(q[1]), .CO(co[1]), .ERR(err[1]));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(MOD_HOUR)) u_hour (
    .CP(clk), .nCLR(nclr), .EN(en_hour), .UP(up[2]), .LD(ld[2]), .D(d[2]),
    .Q(q[2]), .CO(co[2]), .ERR(err[2]));

  // Decimal value to two-digit packed BCD
  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic l, input logic e,
                       input logic u, input logic [7:0] dv);
    ld[i] = l;
    en[i] = e;
    up[i] = u;
    d[i]  = dv;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i]   = 0;
      merr[i] = 0;
    end
  endtask

  // Check CO before the edge, advance one edge, check Q and ERR after it
  task automatic step();
    int   nv[3];
    int   ne[3];
    logic ee[3];
    logic cm[3];
    int   lo, hi;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0)    ee[i] = en[0];
      else if (casc) ee[i] = cm[i-1];
      else           ee[i] = en[i];
      cm[i] = ee[i] && (up[i] ? (mv[i] == mods[i] - 1) : (mv[i] == 0));
      check("co", i, 32'(co[i]), 32'(cm[i]));
    end
    for (int i = 0; i < 3; i++) begin
      ne[i] = 0;
      nv[i] = mv[i];
      if (ld[i]) begin
        lo = int'(d[i][3:0]);
        hi = int'(d[i][7:4]);
        if (lo <= 9 && hi <= 9 && (hi * 10 + lo) < mods[i]) begin
          nv[i] = hi * 10 + lo;
        end else begin
          nv[i] = 0;
          ne[i] = 1;
        end
      end else if (ee[i]) begin
        nv[i] = up[i] ? (mv[i] + 1) % mods[i] : (mv[i] + mods[i] - 1) % mods[i];
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mv[i]   = nv[i];
      merr[i] = ne[i];
      check("q", i, 32'(q[i]), 32'(bcd2(mv[i])));
      check("err", i, 32'(err[i]), 32'(merr[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mods[0] = MOD_SEC;
    mods[1] = MOD_MIN;
    mods[2] = MOD_HOUR;
    nclr = 1'b0;
    casc = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b1, 8'h00);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_q", i, 32'(q[i]), 32'h00);
      check("rst_err", i, 32'(err[i]), 32'h0);
      check("rst_co", i, 32'(co[i]), 32'h0);
    end
    nclr = 1'b1;

    // Asynchronous reset mid-count at 37, then count from zero
    drive(0, 1'b1, 1'b0, 1'b1, 8'h36); step();
    drive(0, 1'b0, 1'b1, 1'b1, 8'h00); step();
    nclr = 1'b0;
    #1;
    model_reset();
    check("async_q", 0, 32'(q[0]), 32'h00);
    check("async_err", 0, 32'(err[0]), 32'h0);
    #1;
    nclr = 1'b1;
    step();
    check("after_rst", 0, 32'(q[0]), 32'h01);

    // Up wrap, modulus 60, plus a digit carry
    drive(0, 1'b1, 1'b0, 1'b1, 8'h58); step();
    drive(0, 1'b0, 1'b1, 1'b1, 8'h00);
    step(); step(); step();
    drive(0, 1'b1, 1'b0, 1'b1, 8'h09); step();
    drive(0, 1'b0, 1'b1, 1'b1, 8'h00); step();
    check("carry_09_10", 0, 32'(q[0]), 32'h10);
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Down wrap, modulus 24, plus a digit borrow
    drive(2, 1'b1, 1'b0, 1'b0, 8'h01); step();
    drive(2, 1'b0, 1'b1, 1'b0, 8'h00);
    step(); step();
    check("down_wrap", 2, 32'(q[2]), 32'h23);
    drive(2, 1'b1, 1'b0, 1'b0, 8'h20); step();
    drive(2, 1'b0, 1'b1, 1'b0, 8'h00); step();
    check("borrow_20_19", 2, 32'(q[2]), 32'h19);

    // Illegal loads on modulus 24
    drive(2, 1'b1, 1'b0, 1'b1, 8'h25); step();
    drive(2, 1'b0, 1'b0, 1'b1, 8'h00); step();
    drive(2, 1'b1, 1'b0, 1'b1, 8'h1A); step();
    drive(2, 1'b1, 1'b0, 1'b1, 8'h23); step();
    drive(2, 1'b0, 1'b0, 1'b1, 8'h00); step();

    // Load beats count; hold with EN=0
    drive(0, 1'b1, 1'b0, 1'b1, 8'h59); step();
    drive(0, 1'b1, 1'b1, 1'b1, 8'h12); step();
    check("ld_priority", 0, 32'(q[0]), 32'h12);
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (5) step();

    // Cascade 23:59:59 -> 00:00:00
    drive(0, 1'b1, 1'b0, 1'b1, 8'h59);
    drive(1, 1'b1, 1'b0, 1'b1, 8'h59);
    drive(2, 1'b1, 1'b0, 1'b1, 8'h23);
    step();
    drive(0, 1'b0, 1'b1, 1'b1, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(2, 1'b0, 1'b0, 1'b1, 8'h00);
    casc = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("casc_co", i, 32'(co[i]), 32'h1);
    step();
    for (int i = 0; i < 3; i++) check("casc_q", i, 32'(q[i]), 32'h00);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      casc = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        ld[i] = ($urandom_range(0, 7) == 0);
        en[i] = 1'($urandom);
        up[i] = 1'($urandom);
        if ($urandom_range(0, 1) == 0)
          d[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        else
          d[i] = 8'($urandom);
      end
      step();
      if (k % 97 == 96) begin
        nclr = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) check("rand_rst_q", i, 32'(q[i]), 32'h00);
        nclr = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
